// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder
// Receives a frame of active-low 7-segment symbols, MSD first, over a
// valid/ready stream. It accumulates a sign-magnitude number from the frame and
// returns the result as a saturated two's-complement value, with err and ovf
// flags.
//
// Optional feature macro: SEG7_HEX_EN
//   When defined, the symbols A..F also decode (as 10..15) and digits
//   accumulate in base 16. When undefined, the decoder is decimal only and
//   those six patterns are invalid.
//
// Handshake semantics (both ports):
//   - A transfer happens on the rising edge where valid and ready are both 1.
//   - A producer must hold its payload stable while valid=1 and ready=0.
//   - The block never makes ready depend on valid in the same cycle:
//       seg_ready is 1 only in COLLECT, and out_valid is 1 only in HOLD.
//   - While out_valid=1, the outputs value, err and ovf do not change.
//
// Debug: state_dbg is 1 while the FSM is in HOLD.

module seg7_frame_decoder #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    input  logic             seg_valid,
    input  logic             seg_last,
    output logic             seg_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] value,
    output logic             err,
    output logic             ovf,
    output logic             state_dbg
);

    // The magnitude register has one spare bit, so it can hold 2^(WIDTH-1)
    // exactly. The accumulator has extra headroom for mag*16+15 before the
    // saturation clamp is applied.
    localparam int MAGW = WIDTH + 1;
    localparam int ACCW = WIDTH + 5;
    localparam int CNTW = $clog2(DIGITS + 2);

    localparam logic [MAGW-1:0]  LIMIT_M = MAGW'(1) << (WIDTH - 1);
    localparam logic [ACCW-1:0]  LIMIT_A = ACCW'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] VMAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] VMIN    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNTW-1:0]  CNT_MAX = CNTW'(DIGITS);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SYM_DIGIT = 2'd0,
        SYM_MINUS = 2'd1,
        SYM_BLANK = 2'd2,
        SYM_BAD   = 2'd3
    } sym_kind_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            take;

    sym_kind_t       sym_kind;
    logic [3:0]      sym_digit;

    // Per-frame working state
    logic [MAGW-1:0] mag;
    logic            neg;
    logic            seen_digit;
    logic            err_acc;
    logic            ovf_acc;
    logic [CNTW-1:0] cnt;

    // The same working state, updated by the symbol at the input
    logic [ACCW-1:0] mag_ext;
    logic [ACCW-1:0] acc_sum;
    logic [MAGW-1:0] nxt_mag;
    logic            nxt_neg;
    logic            nxt_seen_digit;
    logic            nxt_err;
    logic            nxt_ovf;
    logic [CNTW-1:0] nxt_cnt;

    // The result for a frame that ends with the current symbol
    logic [WIDTH-1:0] fin_value;
    logic             fin_err;
    logic             fin_ovf;

    // State register; reset returns to COLLECT and discards any pending result
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_nxt = state;
        seg_ready = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        take      = 1'b0;
        case (state)
            S_COLLECT: begin
                seg_ready = 1'b1;
                if (seg_valid) begin
                    accept = 1'b1;
                    if (seg_last) begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    take      = 1'b1;
                    state_nxt = S_COLLECT;
                end
            end
            default: state_nxt = S_COLLECT;
        endcase
    end

    assign state_dbg = (state == S_HOLD);

    // Symbol classification; any pattern not listed is invalid
    always_comb begin
        sym_kind  = SYM_BAD;
        sym_digit = 4'd0;
        case (seg_in)
            7'b1000000: begin sym_kind = SYM_DIGIT; sym_digit = 4'd0;  end
            7'b1111001: begin sym_kind = SYM_DIGIT; sym_digit = 4'd1;  end
            7'b0100100: begin sym_kind = SYM_DIGIT; sym_digit = 4'd2;  end
            7'b0110000: begin sym_kind = SYM_DIGIT; sym_digit = 4'd3;  end
            7'b0011001: begin sym_kind = SYM_DIGIT; sym_digit = 4'd4;  end
            7'b0010010: begin sym_kind = SYM_DIGIT; sym_digit = 4'd5;  end
            7'b0000010: begin sym_kind = SYM_DIGIT; sym_digit = 4'd6;  end
            7'b1111000: begin sym_kind = SYM_DIGIT; sym_digit = 4'd7;  end
            7'b0000000: begin sym_kind = SYM_DIGIT; sym_digit = 4'd8;  end
            7'b0010000: begin sym_kind = SYM_DIGIT; sym_digit = 4'd9;  end
`ifdef SEG7_HEX_EN
            7'b0001000: begin sym_kind = SYM_DIGIT; sym_digit = 4'd10; end
            7'b0000011: begin sym_kind = SYM_DIGIT; sym_digit = 4'd11; end
            7'b1000110: begin sym_kind = SYM_DIGIT; sym_digit = 4'd12; end
            7'b0100001: begin sym_kind = SYM_DIGIT; sym_digit = 4'd13; end
            7'b0000110: begin sym_kind = SYM_DIGIT; sym_digit = 4'd14; end
            7'b0001110: begin sym_kind = SYM_DIGIT; sym_digit = 4'd15; end
`endif
            7'b0111111: sym_kind = SYM_MINUS;
            7'b1111111: sym_kind = SYM_BLANK;
            default:    sym_kind = SYM_BAD;
        endcase
    end

    // Grammar check and accumulation of one symbol into the working state
    always_comb begin
        mag_ext = {{(ACCW-MAGW){1'b0}}, mag};
`ifdef SEG7_HEX_EN
        acc_sum = (mag_ext << 4) + {{(ACCW-4){1'b0}}, sym_digit};
`else
        acc_sum = (mag_ext << 3) + (mag_ext << 1) + {{(ACCW-4){1'b0}}, sym_digit};
`endif
        nxt_mag        = mag;
        nxt_neg        = neg;
        nxt_seen_digit = seen_digit;
        nxt_err        = err_acc;
        nxt_ovf        = ovf_acc;
        nxt_cnt        = cnt;

        if (cnt == CNT_MAX) begin
            // One symbol past the frame length limit
            nxt_err = 1'b1;
        end else begin
            nxt_cnt = cnt + 1'b1;
        end

        // Once err is set, the rest of the frame is only drained
        if (!err_acc && (cnt != CNT_MAX)) begin
            case (sym_kind)
                SYM_DIGIT: begin
                    nxt_seen_digit = 1'b1;
                    if (acc_sum > LIMIT_A) begin
                        nxt_ovf = 1'b1;
                        nxt_mag = LIMIT_M;
                    end else begin
                        nxt_mag = acc_sum[MAGW-1:0];
                    end
                end
                SYM_MINUS: begin
                    if (neg || seen_digit) begin
                        nxt_err = 1'b1;
                    end else begin
                        nxt_neg = 1'b1;
                    end
                end
                SYM_BLANK: begin
                    if (neg || seen_digit) begin
                        nxt_err = 1'b1;
                    end
                end
                default: nxt_err = 1'b1;
            endcase
        end

        // A minus sign that no digit follows is malformed
        if (seg_last && nxt_neg && !nxt_seen_digit) begin
            nxt_err = 1'b1;
        end
    end

    // Final signed value with saturation; err forces a clean zero result
    always_comb begin
        fin_value = '0;
        fin_err   = nxt_err;
        fin_ovf   = 1'b0;
        if (nxt_err) begin
            fin_value = '0;
            fin_ovf   = 1'b0;
        end else if (nxt_neg) begin
            if (nxt_mag > LIMIT_M) begin
                fin_value = VMIN;
                fin_ovf   = 1'b1;
            end else begin
                // mag == 2^(WIDTH-1) negates to the most negative code
                fin_value = (~nxt_mag[WIDTH-1:0]) + {{(WIDTH-1){1'b0}}, 1'b1};
                fin_ovf   = nxt_ovf;
            end
        end else if (nxt_mag >= LIMIT_M) begin
            fin_value = VMAX;
            fin_ovf   = 1'b1;
        end else begin
            fin_value = nxt_mag[WIDTH-1:0];
            fin_ovf   = nxt_ovf;
        end
    end

    // Working-state and result registers. The working state is cleared when
    // the result is taken. The result registers load on the last symbol only.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag        <= '0;
            neg        <= 1'b0;
            seen_digit <= 1'b0;
            err_acc    <= 1'b0;
            ovf_acc    <= 1'b0;
            cnt        <= '0;
            value      <= '0;
            err        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (accept) begin
                if (seg_last) begin
                    value <= fin_value;
                    err   <= fin_err;
                    ovf   <= fin_ovf;
                end else begin
                    mag        <= nxt_mag;
                    neg        <= nxt_neg;
                    seen_digit <= nxt_seen_digit;
                    err_acc    <= nxt_err;
                    ovf_acc    <= nxt_ovf;
                    cnt        <= nxt_cnt;
                end
            end
            if (take) begin
                mag        <= '0;
                neg        <= 1'b0;
                seen_digit <= 1'b0;
                err_acc    <= 1'b0;
                ovf_acc    <= 1'b0;
                cnt        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed and random frames for seg7_frame_decoder. Expected results are
// queued when a frame is driven and compared when the result appears.
module tb_seg7_frame_decoder;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 6;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_MINUS = 7'b0111111;
    localparam logic [6:0] S_BAD   = 7'b0000001;
    localparam logic [6:0] S_HEXA  = 7'b0001000;
    localparam logic [6:0] S_HEXB  = 7'b0000011;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       seg_in = S_BLANK;
    logic             seg_valid = 1'b0;
    logic             seg_last = 1'b0;
    logic             seg_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] value;
    logic             err;
    logic             ovf;
    logic             state_dbg;

    logic [WIDTH+1:0] exp_q[$];
    logic [6:0]       frame_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               n_fail   = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    seg7_frame_decoder #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .seg_last  (seg_last),
        .seg_ready (seg_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .value     (value),
        .err       (err),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic e, input logic o, input logic [WIDTH-1:0] v);
        exp_q.push_back({e, o, v});
    endtask

    // Append the decimal digits of v (MSD first) to the frame being built
    task automatic add_num(input int v);
        int tmp[$];
        int x;
        x = v;
        if (x == 0) tmp.push_back(0);
        while (x > 0) begin
            tmp.push_front(x % 10);
            x = x / 10;
        end
        foreach (tmp[i]) frame_q.push_back(enc(tmp[i]));
    endtask

    // driver: one symbol, held until accepted
    task automatic send_sym(input logic [6:0] s, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        seg_in    = s;
        seg_last  = l;
        seg_valid = 1'b1;
        while (seg_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("seg_ready_timeout", {31'd0, seg_ready}, 32'd1);
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        seg_last  = 1'b0;
    endtask

    // driver: the whole frame built in frame_q; result must appear one cycle later
    task automatic send_frame(input string tag);
        int n;
        n = frame_q.size();
        for (int i = 0; i < n; i++) send_sym(frame_q[i], (i == n - 1));
        frame_q.delete();
        check({tag, "_latency"}, {31'd0, out_valid}, 32'd1);
    endtask

    // scoreboard: wait for a result, compare against the queue head, then take it
    task automatic get_result(input string tag);
        logic [WIDTH+1:0] e;
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check({tag, "_out_valid_timeout"}, {31'd0, out_valid}, 32'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_exp_q_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_value"}, {16'd0, value}, {16'd0, e[WIDTH-1:0]});
            check({tag, "_err"},   {31'd0, err},   {31'd0, e[WIDTH+1]});
            check({tag, "_ovf"},   {31'd0, ovf},   {31'd0, e[WIDTH]});
            check({tag, "_seg_ready_low"}, {31'd0, seg_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_released"}, {30'd0, out_valid, seg_ready}, 32'd1);
    endtask

    initial begin
        int rv;
        int rneg;
        int nd;
        int nb;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_seg_ready", {31'd0, seg_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_value",     {16'd0, value},     32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        check("rst_ovf",       {31'd0, ovf},       32'd0);

        // blank, blank, 3, 4 -> 34
        push_exp(1'b0, 1'b0, 16'h0022);
        frame_q = '{S_BLANK, S_BLANK, enc(3), enc(4)};
        send_frame("blank34");
        get_result("blank34");

        // -128
        push_exp(1'b0, 1'b0, 16'hFF80);
        frame_q = '{S_MINUS, enc(1), enc(2), enc(8)};
        send_frame("neg128");
        get_result("neg128");

        // 32768 positive saturates
        push_exp(1'b0, 1'b1, 16'h7FFF);
        add_num(32768);
        send_frame("pos32768");
        get_result("pos32768");

        // -32768 is exactly representable, six symbols is the limit
        push_exp(1'b0, 1'b0, 16'h8000);
        frame_q.push_back(S_MINUS);
        add_num(32768);
        send_frame("neg32768");
        get_result("neg32768");

        // -99999 saturates negative
        push_exp(1'b0, 1'b1, 16'h8000);
        frame_q.push_back(S_MINUS);
        add_num(99999);
        send_frame("neg99999");
        get_result("neg99999");

        // minus after digit
        push_exp(1'b1, 1'b0, 16'h0000);
        frame_q = '{enc(1), S_MINUS};
        send_frame("minus_after_digit");
        get_result("minus_after_digit");

        // invalid symbol mid-frame
        push_exp(1'b1, 1'b0, 16'h0000);
        frame_q = '{enc(1), S_BAD, enc(2)};
        send_frame("bad_symbol");
        get_result("bad_symbol");

        // DIGITS+1 symbols; value would also overflow, err wins
        push_exp(1'b1, 1'b0, 16'h0000);
        add_num(1111111);
        send_frame("too_long");
        get_result("too_long");

        // all blank
        push_exp(1'b0, 1'b0, 16'h0000);
        frame_q = '{S_BLANK, S_BLANK};
        send_frame("all_blank");
        get_result("all_blank");

        // lone minus
        push_exp(1'b1, 1'b0, 16'h0000);
        frame_q = '{S_MINUS};
        send_frame("lone_minus");
        get_result("lone_minus");

        // blank after digit
        push_exp(1'b1, 1'b0, 16'h0000);
        frame_q = '{enc(5), S_BLANK};
        send_frame("blank_after_digit");
        get_result("blank_after_digit");

        // hex symbols A, b
`ifdef SEG7_HEX_EN
        push_exp(1'b0, 1'b0, 16'h00AB);
`else
        push_exp(1'b1, 1'b0, 16'h0000);
`endif
        frame_q = '{S_HEXA, S_HEXB};
        send_frame("hex_ab");
        get_result("hex_ab");

        // back-pressure: result held 5 cycles while the producer already waits
        push_exp(1'b0, 1'b0, 16'h0007);
        push_exp(1'b0, 1'b0, 16'h0009);
        frame_q = '{enc(7)};
        send_frame("bp");
        seg_in    = enc(9);
        seg_last  = 1'b1;
        seg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_seg_ready", {31'd0, seg_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_value",     {16'd0, value},     32'd7);
        end
        get_result("bp");
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        seg_last  = 1'b0;
        check("bp_followup_latency", {31'd0, out_valid}, 32'd1);
        get_result("bp_followup");

        // reset after two symbols discards the partial frame
        send_sym(enc(1), 1'b0);
        send_sym(enc(2), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_seg_ready", {31'd0, seg_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        push_exp(1'b0, 1'b0, 16'h0007);
        frame_q = '{enc(7)};
        send_frame("after_rst");
        get_result("after_rst");

        // reset in HOLD, together with out_ready, drops the pending result
        frame_q = '{S_MINUS, enc(5)};
        send_frame("hold_rst");
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b0;
        check("hold_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("hold_rst_value",     {16'd0, value},     32'd0);
        check("hold_rst_seg_ready", {31'd0, seg_ready}, 32'd1);

        // random in-range signed frames with random leading blanks
        for (int k = 0; k < 8; k++) begin
            rv   = $urandom_range(0, 32767);
            rneg = $urandom_range(0, 1);
            nd   = (rv >= 10000) ? 5 : (rv >= 1000) ? 4 : (rv >= 100) ? 3 : (rv >= 10) ? 2 : 1;
            nb   = $urandom_range(0, DIGITS - nd - rneg);
            for (int b = 0; b < nb; b++) frame_q.push_back(S_BLANK);
            if (rneg != 0) frame_q.push_back(S_MINUS);
            add_num(rv);
            push_exp(1'b0, 1'b0, (rneg != 0) ? WIDTH'(-rv) : WIDTH'(rv));
            send_frame("rand");
            get_result("rand");
        end

        check("exp_q_drained", exp_q.size(), 32'd0);

        // report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
